// File: rtl/data_memory_ctrl.sv
// Single-port word memory with byte-lane writes, a one-cycle response path and a
// zero-fill sweep that runs after reset and on every clear pulse.
module data_memory_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    input  logic              clear,
    output logic              busy
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        SERVE
    } state_t;

    state_t            r_state;
    logic [IDX_W-1:0]  r_cnt;
    logic              r_rspValid;
    logic              r_rspErr;
    logic [DATA_W-1:0] r_rspRdata;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_accept;
    logic              w_inRange;
    logic              w_sweepWe;
    logic              w_memWe;
    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_old;
    logic [DATA_W-1:0] w_merged;

    assign w_accept  = req_valid && (r_state == SERVE);
    assign w_inRange = ({1'b0, req_addr} < DEPTH_L);
    assign w_idx     = req_addr[IDX_W-1:0];
    assign w_old     = r_mem[w_idx];
    assign w_sweepWe = (r_state == CLEAR);
    assign w_memWe   = w_accept && req_we && w_inRange;

    always_comb begin
        w_merged = w_old;
        for (int i = 0; i < NB; i++) begin
            if (req_be[i]) begin
                w_merged[8*i +: 8] = req_wdata[8*i +: 8];
            end
        end
    end

    // The merged word is written whole, so an all-zero byte enable rewrites the old value.
    always_ff @(posedge clk) begin
        if (w_sweepWe) begin
            r_mem[r_cnt] <= '0;
        end else if (w_memWe) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= CLEAR;
            r_cnt      <= '0;
            r_rspValid <= 1'b0;
            r_rspErr   <= 1'b0;
            r_rspRdata <= '0;
        end else begin
            r_rspValid <= w_accept;
            if (w_accept) begin
                r_rspErr <= !w_inRange;
                if (!w_inRange) begin
                    r_rspRdata <= '0;
                end else if (req_we) begin
                    r_rspRdata <= w_merged;
                end else begin
                    r_rspRdata <= w_old;
                end
            end
            case (r_state)
                CLEAR: begin
                    if (clear) begin
                        r_cnt <= '0;
                    end else if (r_cnt == LAST_IDX) begin
                        r_state <= SERVE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + IDX_W'(1);
                    end
                end
                SERVE: begin
                    if (clear) begin
                        r_state <= CLEAR;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= CLEAR;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign req_ready = (r_state == SERVE);
    assign busy      = (r_state == CLEAR);
    assign rsp_valid = r_rspValid;
    assign rsp_rdata = r_rspRdata;
    assign rsp_err   = r_rspErr;

endmodule

// File: doc/data_memory_ctrl.md
DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the word width in bits, which must be a multiple of 8.
REQ-002 The block SHALL have parameter ADDR_W, default 8, meaning the address width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 256, meaning the number of words, with DEPTH <= 2**ADDR_W.
REQ-004 The block SHALL define NB = DATA_W/8 as the number of byte lanes.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port req_valid, input, 1 bit: the request is present.
REQ-008 The block SHALL have port req_ready, output, 1 bit: the block accepts the request this cycle.
REQ-009 The block SHALL have port req_we, input, 1 bit: 1 = write, 0 = read.
REQ-010 The block SHALL have port req_addr, input, ADDR_W bits: the word address.
REQ-011 The block SHALL have port req_wdata, input, DATA_W bits: the write data.
REQ-012 The block SHALL have port req_be, input, NB bits: the per-byte write enables.
REQ-013 The block SHALL have port rsp_valid, output, 1 bit: rsp_rdata and rsp_err are valid this cycle.
REQ-014 The block SHALL have port rsp_rdata, output, DATA_W bits: the read data.
REQ-015 The block SHALL have port rsp_err, output, 1 bit: the accepted request addressed a word >= DEPTH.
REQ-016 The block SHALL have port clear, input, 1 bit: a one-cycle pulse that requests a full zero-fill of the memory.
REQ-017 The block SHALL have port busy, output, 1 bit: a clear sweep is in progress.

Function
REQ-018 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1; req_ready=1 exactly when the FSM is in state SERVE.
REQ-019 The FSM SHALL have states CLEAR and SERVE: reset leads to CLEAR; CLEAR goes to SERVE after the last word is written; SERVE goes to CLEAR on clear=1.
REQ-020 In CLEAR, the block SHALL write 0 to one word per cycle at addresses 0 to DEPTH-1 using an internal counter, taking exactly DEPTH cycles, with busy=1 and req_ready=0.
REQ-021 A clear pulse during CLEAR SHALL restart the counter at 0.
REQ-022 When clear=1 and req_valid=1 in the same SERVE cycle, the request SHALL be accepted and completed, and CLEAR SHALL start on the next cycle.
REQ-023 An accepted write SHALL update only the byte lanes where req_be[i]=1; the other lanes keep their value.
REQ-024 An accepted write with req_be all zero SHALL leave the memory unchanged and still produce a response.
REQ-025 An accepted read SHALL produce rsp_valid=1 and rsp_rdata = mem[req_addr] exactly one cycle after acceptance (latency 1).
REQ-026 An accepted write SHALL produce rsp_valid=1 one cycle after acceptance, with rsp_rdata = the new merged word (write-first).
REQ-027 A read in the cycle immediately after a write to the same address SHALL return the written data; there is no stale-read hazard.
REQ-028 Back-to-back requests SHALL be accepted every cycle in SERVE, giving one response per cycle.
REQ-029 rsp_valid SHALL be 0 in every cycle that does not follow an acceptance.
REQ-030 rsp_rdata SHALL hold its last value while rsp_valid=0.
REQ-031 If req_addr >= DEPTH, a write SHALL be dropped, a read SHALL return 0, and rsp_err=1 with rsp_valid=1.
REQ-032 rsp_err SHALL be 0 on all other responses.
REQ-033 The memory array SHALL have no reset port; its contents are defined only by the CLEAR sweep.

Reset
REQ-034 While rst_n=0, the block SHALL hold req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=1, state=CLEAR and counter=0, asynchronously.
REQ-035 After rst_n rises, the first CLEAR write SHALL occur on the first rising edge, and req_ready SHALL rise DEPTH cycles later.
REQ-036 A reset asserted mid-sweep or mid-request SHALL abort all activity; no response is issued for the request in flight, and the sweep restarts from 0.

Verification
REQ-037 Release rst_n with DEPTH=256 -> busy=1 for 256 cycles, then req_ready=1; reads of addresses 0, 127 and 255 return 0x00.
REQ-038 Write 0xA5 to address 0x10, then read address 0x10 on the next cycle -> the write response returns 0xA5 and the next response returns 0xA5.
REQ-039 With DATA_W=32: write 0x11223344 with be=1111, then 0xAABBCCDD with be=0101, then read -> returns 0x11BB33DD.
REQ-040 With DEPTH=200 and ADDR_W=8: write 0x55 to address 220, then read address 220 -> both responses have rsp_err=1, and the read returns 0x00; address 199 is unaffected.
REQ-041 Pulse clear at cycle 100 of the sweep -> busy stays 1 and a further 256 cycles elapse before req_ready=1; clear together with an accepted read -> the read response arrives and busy rises the same cycle.
REQ-042 Drop rst_n during a read acceptance -> rsp_valid=0 immediately and no response follows; after release the full 256-cycle sweep repeats.
